// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS load/store unit and its Avalon-MM master port.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // Number of bytes moved by an access of the given size.
  function automatic int size_bytes(size_t s);
    case (s)
      SZ_B:    return 1;
      SZ_H:    return 2;
      SZ_W:    return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/mips_avalon_lsu_if.sv
// Avalon-MM master/slave signal bundle used between the LSU and the bus fabric.
//
// Handshake: the master raises read or write together with address,
// byteenable and writedata and holds all of them stable while waitrequest=1.
// The transfer completes on the first rising edge where the strobe is high and
// waitrequest=0; for reads, readdata is valid in that same cycle.
interface mips_avalon_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic                waitrequest;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_lane_align.sv
// Byte-lane steering: store lane placement, byte enables, alignment check,
// and load extraction with sign/zero extension.
module mips_lane_align
  import mips_bus_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_t                         size,
  input  logic                          unsign,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W-1:0]             rdata,
  output logic                          misaligned,
  output logic [DATA_W/8-1:0]           byteenable,
  output logic [DATA_W-1:0]             writedata,
  output logic [DATA_W-1:0]             load_data
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  logic [LANES-1:0]  size_mask;
  logic [OFF_W-1:0]  align_mask;
  logic [DATA_W-1:0] width_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;
  logic              sign_ext;

  // Per-size lane mask, low-address alignment mask and data-width mask.
  always_comb begin
    size_mask  = LANES'((1 << size_bytes(size)) - 1);
    align_mask = OFF_W'(size_bytes(size) - 1);
    width_mask = '1;
    sign_bit   = shifted[DATA_W-1];
    case (size)
      SZ_B: begin
        width_mask = DATA_W'(64'h0000_0000_0000_00FF);
        sign_bit   = shifted[7];
      end
      SZ_H: begin
        width_mask = DATA_W'(64'h0000_0000_0000_FFFF);
        sign_bit   = shifted[15];
      end
      SZ_W: begin
        width_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
        sign_bit   = shifted[31];
      end
      SZ_D: begin
        width_mask = '1;
        sign_bit   = shifted[DATA_W-1];
      end
    endcase
  end

  // Lane placement for stores, extraction and extension for loads.
  always_comb begin
    shifted    = rdata >> {offset, 3'b000};
    sign_ext   = ~unsign & sign_bit;
    load_data  = (shifted & width_mask) | ({DATA_W{sign_ext}} & ~width_mask);
    byteenable = size_mask << offset;
    writedata  = (wdata & width_mask) << {offset, 3'b000};
    // A dword access cannot be carried by a 32-bit bus, so it is rejected
    // the same way as a misaligned one.
    misaligned = (|(offset & align_mask)) | ((size == SZ_D) && (DATA_W < 64));
  end

endmodule

// File: rtl/mips_avalon_lsu.sv
// Load/store unit: accepts one CPU access, runs it on the Avalon-MM master
// port, and returns aligned/extended load data with an error code.
module mips_avalon_lsu
  import mips_bus_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_unsign,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic [1:0]         resp_err,
  output logic               stall,
  output lsu_state_t         dbg_state,
  mips_avalon_lsu_if.master  bus
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  // The counter only needs to reach TIMEOUT_CYCLES-1: the edge that would
  // make it TIMEOUT_CYCLES is the one that aborts the access.
  localparam int              TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0]   TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t        state;
  logic [TW-1:0]     tcount;
  size_t             size_q;
  logic              unsign_q;
  logic [OFF_W-1:0]  offset_q;

  size_t             al_size;
  logic [OFF_W-1:0]  al_offset;
  logic              al_misaligned;
  logic [LANES-1:0]  al_byteenable;
  logic [DATA_W-1:0] al_writedata;
  logic [DATA_W-1:0] al_load_data;
  logic              timed_out;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;
  assign timed_out = TO_EN && bus.waitrequest && (tcount == TO_LAST);

  // While idle the aligner sees the incoming request; during a read it sees
  // the captured size/offset so readdata is extracted for the right lanes.
  always_comb begin
    al_size   = size_q;
    al_offset = offset_q;
    if (state == IDLE) begin
      al_size   = size_t'(req_size);
      al_offset = req_addr[OFF_W-1:0];
    end
  end

  mips_lane_align #(.DATA_W(DATA_W)) u_align (
    .size       (al_size),
    .unsign     (unsign_q),
    .offset     (al_offset),
    .wdata      (req_wdata),
    .rdata      (bus.readdata),
    .misaligned (al_misaligned),
    .byteenable (al_byteenable),
    .writedata  (al_writedata),
    .load_data  (al_load_data)
  );

  // Access FSM with registered bus strobes, response and timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      tcount         <= '0;
      size_q         <= SZ_B;
      unsign_q       <= 1'b0;
      offset_q       <= '0;
      stall          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= ERR_OK;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q   <= size_t'(req_size);
            unsign_q <= req_unsign;
            offset_q <= req_addr[OFF_W-1:0];
            tcount   <= '0;
            if (al_misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= ERR_MISALIGN;
            end else begin
              state          <= req_write ? WRITE : READ;
              stall          <= 1'b1;
              bus.read       <= ~req_write;
              bus.write      <= req_write;
              bus.address    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus.byteenable <= al_byteenable;
              bus.writedata  <= req_write ? al_writedata : '0;
            end
          end
        end
        READ, WRITE: begin
          if (!bus.waitrequest || timed_out) begin
            state          <= RESP;
            stall          <= 1'b0;
            resp_valid     <= 1'b1;
            tcount         <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.address    <= '0;
            bus.byteenable <= '0;
            bus.writedata  <= '0;
            if (timed_out) begin
              resp_err   <= ERR_TIMEOUT;
              resp_rdata <= '0;
            end else begin
              resp_err   <= ERR_OK;
              resp_rdata <= (state == READ) ? al_load_data : '0;
            end
          end else if (TO_EN) begin
            tcount <= tcount + TW'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Directed bench for mips_avalon_lsu on a 32-bit bus with a 4-cycle timeout.
module tb_mips_avalon_lsu;
  import mips_bus_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_err;
  logic              stall;
  lsu_state_t        dbg_state;

  mips_avalon_lsu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mips_avalon_lsu #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_unsign (req_unsign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request at a falling edge; returns at the falling edge
  // after the accepting rising edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_unsign = uns;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsign = 1'b0;
    req_addr = '0; req_wdata = '0;
    bus.waitrequest = 1'b1;
    bus.readdata = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_addr", bus.address, 32'd0);
    chk("rst_wdata", bus.writedata, 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // lw @0x1004 with three waited cycles
    issue(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0);
    chk("lw_state", 32'(dbg_state), 32'(READ));
    chk("lw_ready", 32'(req_ready), 32'd0);
    chk("lw_stall", 32'(stall), 32'd1);
    chk("lw_write", 32'(bus.write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_read_held", 32'(bus.read), 32'd1);
      chk("lw_addr", bus.address, 32'h1004);
      chk("lw_be", 32'(bus.byteenable), 32'hF);
      chk("lw_no_resp", 32'(resp_valid), 32'd0);
      if (i == 2) begin
        bus.waitrequest = 1'b0;
        bus.readdata = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    chk("lw_resp_valid", 32'(resp_valid), 32'd1);
    chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(resp_err), 32'(ERR_OK));
    chk("lw_read_drop", 32'(bus.read), 32'd0);
    chk("lw_stall_drop", 32'(stall), 32'd0);
    bus.waitrequest = 1'b1;
    bus.readdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("lw_resp_pulse", 32'(resp_valid), 32'd0);
    chk("lw_idle_ready", 32'(req_ready), 32'd1);

    // lb / lbu @0x1003, zero-wait
    bus.waitrequest = 1'b0;
    bus.readdata = 32'h80FFFFFF;
    issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
    chk("lb_be", 32'(bus.byteenable), 32'h8);
    chk("lb_addr", bus.address, 32'h1000);
    chk("lb_read", 32'(bus.read), 32'd1);
    @(negedge clk);
    chk("lb_resp_valid", 32'(resp_valid), 32'd1);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
    @(negedge clk);
    issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
    @(negedge clk);
    chk("lbu_rdata", resp_rdata, 32'h00000080);
    @(negedge clk);

    // lh / lhu @0x1002
    bus.readdata = 32'h92345678;
    issue(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0);
    chk("lh_be", 32'(bus.byteenable), 32'hC);
    @(negedge clk);
    chk("lh_rdata", resp_rdata, 32'hFFFF9234);
    @(negedge clk);
    issue(1'b0, 2'd1, 1'b1, 32'h1000, 32'h0);
    chk("lhu_be", 32'(bus.byteenable), 32'h3);
    @(negedge clk);
    chk("lhu_rdata", resp_rdata, 32'h00005678);
    @(negedge clk);

    // sh @0x2002 and sb @0x5001 (upper store bits must not leak)
    issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD);
    chk("sh_state", 32'(dbg_state), 32'(WRITE));
    chk("sh_write", 32'(bus.write), 32'd1);
    chk("sh_read", 32'(bus.read), 32'd0);
    chk("sh_addr", bus.address, 32'h2000);
    chk("sh_be", 32'(bus.byteenable), 32'hC);
    chk("sh_wdata", bus.writedata, 32'hABCD0000);
    @(negedge clk);
    chk("sh_resp_valid", 32'(resp_valid), 32'd1);
    chk("sh_rdata", resp_rdata, 32'd0);
    chk("sh_err", 32'(resp_err), 32'(ERR_OK));
    chk("sh_write_drop", 32'(bus.write), 32'd0);
    @(negedge clk);
    issue(1'b1, 2'd0, 1'b0, 32'h5001, 32'hFFFFFFA5);
    chk("sb_be", 32'(bus.byteenable), 32'h2);
    chk("sb_wdata", bus.writedata, 32'h0000A500);
    @(negedge clk);
    @(negedge clk);

    // Misaligned lw @0x1002 and sh @0x2001
    issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
    chk("mis_read", 32'(bus.read), 32'd0);
    chk("mis_write", 32'(bus.write), 32'd0);
    chk("mis_resp_valid", 32'(resp_valid), 32'd1);
    chk("mis_err", 32'(resp_err), 32'(ERR_MISALIGN));
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mis_resp_pulse", 32'(resp_valid), 32'd0);
    chk("mis_ready", 32'(req_ready), 32'd1);
    issue(1'b1, 2'd1, 1'b0, 32'h2001, 32'h1234);
    chk("mis_sh_err", 32'(resp_err), 32'(ERR_MISALIGN));
    chk("mis_sh_write", 32'(bus.write), 32'd0);
    @(negedge clk);

    // Timeout with waitrequest stuck high; a request while busy is ignored
    bus.waitrequest = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_read_held", 32'(bus.read), 32'd1);
      chk("to_no_resp", 32'(resp_valid), 32'd0);
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h6000;
      end
      if (i == 2) begin
        chk("busy_write_ignored", 32'(bus.write), 32'd0);
        chk("busy_addr_kept", bus.address, 32'h3000);
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("to_read_drop", 32'(bus.read), 32'd0);
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_err", 32'(resp_err), 32'(ERR_TIMEOUT));
    chk("to_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("to_resp_pulse", 32'(resp_valid), 32'd0);
    chk("to_idle", 32'(dbg_state), 32'(IDLE));

    // Reset during a waited store, then a normal load
    issue(1'b1, 2'd2, 1'b0, 32'h4008, 32'h12345678);
    chk("rw_write", 32'(bus.write), 32'd1);
    chk("rw_wdata", bus.writedata, 32'h12345678);
    #2 reset = 1'b0;
    #1;
    chk("rw_write_async", 32'(bus.write), 32'd0);
    chk("rw_stall_async", 32'(stall), 32'd0);
    chk("rw_state_async", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_no_resp_after", 32'(resp_valid), 32'd0);
    bus.waitrequest = 1'b0;
    bus.readdata = 32'hCAFEF00D;
    issue(1'b0, 2'd2, 1'b1, 32'h1000, 32'h0);
    chk("post_read", 32'(bus.read), 32'd1);
    @(negedge clk);
    chk("post_resp_valid", 32'(resp_valid), 32'd1);
    chk("post_rdata", resp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("post_resp_pulse", 32'(resp_valid), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
